// File: rtl/coef_loader.sv
// coef_loader: parses SYNC/N/coefficient/CHK byte frames from a serial receiver
// and writes 18-bit coefficients into the coefficient RAM. Revision 1.0.
`default_nettype none

module coef_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         TIMEOUT   = 1000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [6:0]  RAM_coefs_addr,
  output logic [17:0] RAM_coefs_datain,
  output logic        RAM_coefs_we,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  coef_count
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    B2    = 3'd2,
    B1    = 3'd3,
    B0    = 3'd4,
    CHECK = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    n_q, n_d;
  logic [6:0]    idx_q, idx_d;
  logic [7:0]    acc_q, acc_d;
  logic [1:0]    b2_q, b2_d;
  logic [7:0]    b1_q, b1_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          we_q, we_d;
  logic [6:0]    addr_q, addr_d;
  logic [17:0]   datain_q, datain_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [7:0]    cnt_q, cnt_d;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      n_q      <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      b2_q     <= '0;
      b1_q     <= '0;
      tmo_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      datain_q <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      b2_q     <= b2_d;
      b1_q     <= b1_d;
      tmo_q    <= tmo_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      datain_q <= datain_d;
      done_q   <= done_d;
      error_q  <= error_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    b2_d     = b2_q;
    b1_d     = b1_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    datain_d = datain_q;
    done_d   = 1'b0;
    error_d  = error_q;
    cnt_d    = cnt_q;
    // Counts consecutive cycles without an accepted byte while a frame is open.
    tmo_d    = (state_q == IDLE || rx_valid) ? '0 : tmo_q + 1'b1;

    if (state_q != IDLE && !rx_valid && tmo_q == TW'(TIMEOUT - 1)) begin
      state_d = IDLE;
      error_d = 1'b1;
    end else if (rx_valid) begin
      case (state_q)
        IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            state_d = COUNT;
            error_d = 1'b0;
            acc_d   = '0;
            idx_d   = '0;
          end
        end
        COUNT: begin
          n_d     = (rx_data == 8'd0 || rx_data > 8'd128) ? 8'd128 : rx_data;
          acc_d   = rx_data;
          state_d = B2;
        end
        B2: begin
          b2_d    = rx_data[1:0];
          acc_d   = acc_q ^ rx_data;
          state_d = B1;
        end
        B1: begin
          b1_d    = rx_data;
          acc_d   = acc_q ^ rx_data;
          state_d = B0;
        end
        B0: begin
          acc_d    = acc_q ^ rx_data;
          we_d     = 1'b1;
          addr_d   = idx_q;
          datain_d = {b2_q, b1_q, rx_data};
          // Last coefficient leaves the index at N-1 so it never wraps.
          if ({1'b0, idx_q} + 8'd1 == n_q) begin
            state_d = CHECK;
          end else begin
            idx_d   = idx_q + 7'd1;
            state_d = B2;
          end
        end
        CHECK: begin
          if (rx_data == acc_q) begin
            done_d = 1'b1;
            cnt_d  = n_q;
          end else begin
            error_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign RAM_coefs_addr   = addr_q;
  assign RAM_coefs_datain = datain_q;
  assign RAM_coefs_we     = we_q;
  assign busy             = (state_q != IDLE);
  assign done             = done_q;
  assign error            = error_q;
  assign coef_count       = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_coef_loader.sv
// tb_coef_loader: randomized frame stimulus against a frame-level reference model.
`default_nettype none

module tb_coef_loader;

  localparam int         TMO  = 40;
  localparam logic [7:0] SYNC = 8'hA5;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [6:0]  RAM_coefs_addr;
  logic [17:0] RAM_coefs_datain;
  logic        RAM_coefs_we;
  logic        busy, done, error;
  logic [7:0]  coef_count;

  coef_loader #(.SYNC_BYTE(SYNC), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .RAM_coefs_addr(RAM_coefs_addr), .RAM_coefs_datain(RAM_coefs_datain),
    .RAM_coefs_we(RAM_coefs_we), .busy(busy), .done(done), .error(error),
    .coef_count(coef_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  logic [24:0] got_q[$];
  logic [24:0] exp_q[$];
  logic [7:0]  frame_q[$];
  logic [7:0]  pre_q[$];
  int          done_cnt = 0;
  bit          exp_ok;
  int          exp_n;
  int          model_count = 0;

  always @(posedge clock) begin
    #1;
    if (RAM_coefs_we) got_q.push_back({RAM_coefs_addr, RAM_coefs_datain});
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send_bytes(input logic [7:0] bq[$], input int maxgap);
    int g;
    foreach (bq[i]) begin
      @(negedge clock);
      rx_valid = 1'b1;
      rx_data  = bq[i];
      g = $urandom_range(maxgap, 0);
      repeat (g) begin
        @(negedge clock);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
      end
    end
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  // Reference model: frame bytes and expected RAM writes from the frame rules.
  task automatic make_frame(input logic [7:0] nraw, input bit bad);
    logic [7:0] x, b2, b1, b0;
    exp_n = (nraw == 8'd0 || nraw > 8'd128) ? 128 : int'(nraw);
    frame_q.delete();
    exp_q.delete();
    frame_q.push_back(SYNC);
    frame_q.push_back(nraw);
    x = nraw;
    for (int k = 0; k < exp_n; k++) begin
      b2 = (pre_q.size() > 0) ? pre_q.pop_front() : 8'($urandom);
      b1 = (pre_q.size() > 0) ? pre_q.pop_front() : 8'($urandom);
      b0 = (pre_q.size() > 0) ? pre_q.pop_front() : 8'($urandom);
      frame_q.push_back(b2);
      frame_q.push_back(b1);
      frame_q.push_back(b0);
      x = x ^ b2 ^ b1 ^ b0;
      exp_q.push_back({7'(k), b2[1:0], b1, b0});
    end
    frame_q.push_back(bad ? (x ^ 8'h01) : x);
    exp_ok = !bad;
  endtask

  task automatic run_frame(input string tag, input int maxgap);
    logic [24:0] last;
    got_q.delete();
    done_cnt = 0;
    send_bytes(frame_q, maxgap);
    repeat (3) @(negedge clock);
    check({tag, "_nwr"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_wr"}, got_q[i], exp_q[i]);
    check({tag, "_done"}, done_cnt, exp_ok ? 1 : 0);
    check({tag, "_err"}, error, exp_ok ? 0 : 1);
    if (exp_ok) model_count = exp_n;
    check({tag, "_cnt"}, coef_count, model_count);
    check({tag, "_busy"}, busy, 0);
    last = exp_q[exp_q.size() - 1];
    check({tag, "_hold"}, {RAM_coefs_addr, RAM_coefs_datain}, last);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_we"}, RAM_coefs_we, 0);
    check({tag, "_addr"}, RAM_coefs_addr, 0);
    check({tag, "_din"}, RAM_coefs_datain, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, error, 0);
    check({tag, "_cnt"}, coef_count, 0);
  endtask

  initial begin
    logic [7:0] junk[$];
    repeat (3) @(negedge clock);
    check_zero("rst");
    reset = 1'b1;
    repeat (2) @(negedge clock);

    pre_q = '{8'h01, 8'h23, 8'h45, 8'h00, 8'h00, 8'h07};
    make_frame(8'h02, 1'b0);
    run_frame("basic", 0);

    pre_q = '{8'h01, 8'h23, 8'h45, 8'h00, 8'h00, 8'h07};
    make_frame(8'h02, 1'b1);
    run_frame("badchk", 1);

    junk = '{8'h55};
    send_bytes(junk, 0);
    pre_q = '{8'hFF, 8'hFF, 8'hFF};
    make_frame(8'h01, 1'b0);
    run_frame("ffmask", 0);
    check("ffmask_din", RAM_coefs_datain, 18'h3FFFF);

    make_frame(8'h00, 1'b0);
    run_frame("full128", 0);

    for (int f = 0; f < 16; f++) begin
      make_frame(8'($urandom_range(255, 0)), ($urandom_range(3, 0) == 0));
      run_frame("rand", $urandom_range(2, 0));
    end

    // Frame stalls after the first coefficient byte.
    got_q.delete();
    frame_q = '{SYNC, 8'h01, 8'h03};
    send_bytes(frame_q, 0);
    repeat (TMO / 2) @(negedge clock);
    check("tmo_busy_mid", busy, 1);
    check("tmo_err_mid", error, 0);
    repeat (TMO) @(negedge clock);
    check("tmo_err", error, 1);
    check("tmo_busy", busy, 0);
    check("tmo_nwr", got_q.size(), 0);
    make_frame(8'd3, 1'b0);
    run_frame("after_tmo", 1);

    // Reset lands after the B1 byte.
    got_q.delete();
    frame_q = '{SYNC, 8'h01, 8'h11, 8'h22};
    send_bytes(frame_q, 0);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check_zero("midrst");
    model_count = 0;
    repeat (3) @(negedge clock);
    check("midrst_nwr", got_q.size(), 0);
    make_frame(8'd5, 1'b0);
    run_frame("after_rst", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
